// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite bridge memory side.
// Responder FSM states and latched operation kind.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_rsp_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_t;

  // Width of a down-counter able to hold lat-1.
  function automatic int cnt_width(input int lat);
    return (lat > 2) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/mem_sram_1rw.sv
// Single-port word array: one access per clock.
// Writes commit at the edge; reads land in a held output register.
module mem_sram_1rw #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 1024,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Read register: only a read access updates it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_en && !i_we) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi4_lite_mem_responder.sv
// Memory-side responder: one request at a time,
// fixed latency, one-cycle completion pulse.
module axi4_lite_mem_responder
  import axi4_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_request_mem,
  input  logic                  write_request_mem,
  input  logic [ADDR_WIDTH-1:0] read_address_mem,
  input  logic [ADDR_WIDTH-1:0] write_address_mem,
  input  logic [DATA_WIDTH-1:0] write_data_mem,
  output logic [DATA_WIDTH-1:0] read_data_mem,
  output logic                  axi_valid_to_mem,
  output logic                  axi_ready_to_mem
);

  localparam int OFF_W = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(LATENCY);

  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  mem_rsp_state_t        r_state;
  mem_rsp_state_t        w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  r_ready;
  logic                  w_ready_nxt;
  logic                  r_valid;
  logic                  w_valid_nxt;
  mem_op_t               r_op;
  mem_op_t               w_op_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] w_wdata_nxt;
  logic                  w_mem_en;
  logic                  w_accept;

  logic [IDX_W-1:0]      w_rd_idx;
  logic [IDX_W-1:0]      w_wr_idx;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused;

  // Byte offset and upper bits drop out: addresses alias.
  assign w_rd_idx = read_address_mem[OFF_W +: IDX_W];
  assign w_wr_idx = write_address_mem[OFF_W +: IDX_W];
  assign w_unused = ^{read_address_mem, write_address_mem};

  // Next-state, counter and request latches.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready_nxt = r_ready;
    w_valid_nxt = 1'b0;
    w_op_nxt    = r_op;
    w_idx_nxt   = r_idx;
    w_wdata_nxt = r_wdata;
    w_mem_en    = 1'b0;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!r_ready) begin
          // Cycle after a completion or reset.
          w_ready_nxt = 1'b1;
        end else if (write_request_mem) begin
          // Write wins; a concurrent read stays pending.
          w_accept    = 1'b1;
          w_op_nxt    = OP_WRITE;
          w_idx_nxt   = w_wr_idx;
          w_wdata_nxt = write_data_mem;
        end else if (read_request_mem) begin
          w_accept  = 1'b1;
          w_op_nxt  = OP_READ;
          w_idx_nxt = w_rd_idx;
        end
        if (w_accept) begin
          w_ready_nxt = 1'b0;
          w_cnt_nxt   = CNT_INIT;
          w_state_nxt = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        w_cnt_nxt = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        // The array access and pulse share this edge.
        w_valid_nxt = 1'b1;
        w_mem_en    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_ready_nxt = 1'b0;
      end
    endcase
  end

  // Control and latch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_op    <= OP_READ;
      r_idx   <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
      r_valid <= w_valid_nxt;
      r_op    <= w_op_nxt;
      r_idx   <= w_idx_nxt;
      r_wdata <= w_wdata_nxt;
    end
  end

  // Reset at the response edge drops the access.
  mem_sram_1rw #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_sram (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_mem_en & ~rst),
    .i_we    (r_op == OP_WRITE),
    .i_addr  (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  assign read_data_mem    = w_rdata;
  assign axi_valid_to_mem = r_valid;
  assign axi_ready_to_mem = r_ready;

endmodule

// File: tb/tb_axi4_lite_mem_responder.sv
// Directed and scoreboard bench for the
// memory responder at LATENCY=4.
module tb_axi4_lite_mem_responder;

  localparam int LAT = 4;

  logic        clk;
  logic        rst;
  logic        rd_req;
  logic        wr_req;
  logic [31:0] rd_addr;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;
  logic [63:0] rd_data;
  logic        valid;
  logic        ready;

  int n_checks;
  int n_err;
  logic [63:0] last_rd;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [63:0] data;
    string       name;
  } vec_t;

  vec_t vecs[9];

  axi4_lite_mem_responder #(
    .DATA_WIDTH (64),
    .ADDR_WIDTH (32),
    .DEPTH      (1024),
    .LATENCY    (LAT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .read_request_mem  (rd_req),
    .write_request_mem (wr_req),
    .read_address_mem  (rd_addr),
    .write_address_mem (wr_addr),
    .write_data_mem    (wr_data),
    .read_data_mem     (rd_data),
    .axi_valid_to_mem  (valid),
    .axi_ready_to_mem  (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({nm, "_ready"}, 64'(ready), 64'd1);
  endtask

  // Called one sample after the accept edge.
  task automatic check_resp(input logic [63:0] exp,
                            input string nm);
    for (int k = 1; k <= LAT; k++) begin
      step();
      if (k < LAT) begin
        chk({nm, "_busy"}, 64'({valid, ready}), 64'd0);
      end else begin
        chk({nm, "_pulse"}, 64'({valid, ready}), 64'd2);
        chk({nm, "_data"}, rd_data, exp);
      end
    end
    step();
    chk({nm, "_after"}, 64'({valid, ready}), 64'd1);
    chk({nm, "_hold"}, rd_data, exp);
  endtask

  task automatic do_op(input bit wr,
                       input logic [31:0] addr,
                       input logic [63:0] data,
                       input string nm);
    if (wr) begin
      wr_req  = 1'b1;
      wr_addr = addr;
      wr_data = data;
    end else begin
      rd_req  = 1'b1;
      rd_addr = addr;
    end
    wait_ready(nm);
    step();
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    wr_addr = $urandom;
    rd_addr = $urandom;
    wr_data = {$urandom, $urandom};
    if (wr) begin
      check_resp(last_rd, nm);
    end else begin
      check_resp(data, nm);
      last_rd = data;
    end
  endtask

  bit          seen[16];
  logic [63:0] model[16];

  initial begin
    vecs[0] = '{1'b1, 32'h1234_5678,
                64'hABCD_1234_ECEB_1234, "wr_main"};
    vecs[1] = '{1'b0, 32'h1234_5678,
                64'hABCD_1234_ECEB_1234, "rd_main"};
    vecs[2] = '{1'b1, 32'h0000_2008,
                64'h0000_0000_0000_DEAD, "wr_alias"};
    vecs[3] = '{1'b0, 32'h0000_0008,
                64'h0000_0000_0000_DEAD, "rd_alias"};
    vecs[4] = '{1'b1, 32'h0000_0000,
                64'h0123_4567_89AB_CDEF, "wr_zero"};
    vecs[5] = '{1'b0, 32'h0000_0007,
                64'h0123_4567_89AB_CDEF, "rd_offset"};
    vecs[6] = '{1'b1, 32'h0000_1FF8,
                64'h5555_AAAA_5555_AAAA, "wr_top"};
    vecs[7] = '{1'b0, 32'hFFFF_FFF8,
                64'h5555_AAAA_5555_AAAA, "rd_top"};
    vecs[8] = '{1'b0, 32'h1234_5678,
                64'hABCD_1234_ECEB_1234, "rd_again"};

    n_checks = 0;
    n_err    = 0;
    last_rd  = '0;
    rst      = 1'b1;
    rd_req   = 1'b0;
    wr_req   = 1'b0;
    rd_addr  = '0;
    wr_addr  = '0;
    wr_data  = '0;

    // Reset behaviour.
    repeat (5) begin
      step();
      chk("rst_ready", 64'(ready), 64'd0);
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_rdata", rd_data, 64'd0);
    end
    rst = 1'b0;
    step();
    chk("post_rst_ready", 64'(ready), 64'd1);
    chk("post_rst_valid", 64'(valid), 64'd0);
    step();
    chk("idle_hold", 64'({valid, ready}), 64'd1);

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].wr, vecs[i].addr,
            vecs[i].data, vecs[i].name);
    end

    // Read and write together: write first.
    wr_req  = 1'b1;
    wr_addr = 32'h40;
    wr_data = 64'h1;
    rd_req  = 1'b1;
    rd_addr = 32'h40;
    wait_ready("simul");
    step();
    wr_req  = 1'b0;
    wr_data = 64'hBAD;
    check_resp(last_rd, "simul_wr");
    step();
    rd_req = 1'b0;
    check_resp(64'h1, "simul_rd");
    last_rd = 64'h1;

    // Reset during a write in flight.
    do_op(1'b1, 32'h80, 64'h77, "pre_wr");
    wr_req  = 1'b1;
    wr_addr = 32'h80;
    wr_data = 64'hFF;
    wait_ready("abort");
    step();
    wr_req = 1'b0;
    step();
    step();
    rst = 1'b1;
    repeat (2) begin
      step();
      chk("abort_rst_vr", 64'({valid, ready}), 64'd0);
    end
    rst     = 1'b0;
    last_rd = '0;
    chk("abort_rdata", rd_data, 64'd0);
    repeat (6) begin
      step();
      chk("abort_nopulse", 64'(valid), 64'd0);
    end
    do_op(1'b0, 32'h80, 64'h77, "abort_rd");

    // Random back-to-back ops against a model.
    for (int i = 0; i < 50; i++) begin
      int unsigned idx;
      bit          wr;
      logic [31:0] a;
      logic [63:0] d;
      idx = $urandom_range(0, 15);
      wr  = !seen[idx] || ($urandom_range(0, 1) == 1);
      a   = ($urandom & ~32'h1FF8) |
            (32'(512 + idx) << 3);
      if (wr) begin
        d          = {$urandom, $urandom};
        model[idx] = d;
        seen[idx]  = 1'b1;
      end else begin
        d = model[idx];
      end
      do_op(wr, a, d, wr ? "rnd_wr" : "rnd_rd");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
